positron_layer_sequencer: RTL and testbench

- Controls one fully-connected layer built from NB_POSITRON parallel positron engines.
- On start, streams NB_UPSTREAM activations from an activation RAM into all positrons in lock-step, with framing (sow/eow).
- Collects one result per positron at end-of-window, then writes the results sequentially into a result RAM.
- Sits between the layer's activation/result buffers and the positron array; one instance per layer.

---
 rtl/positron_layer_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_positron_layer_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/positron_layer_sequencer.sv
// ---------------------------------------------------------------------------
// positron_layer_sequencer
//
// Sequences one fully-connected layer built from NB_POSITRON positron engines.
// On start it streams NB_UPSTREAM activations from the activation RAM to all
// positrons in lock-step, with sow/eow framing. It then collects one result
// per positron, writes the results one per cycle into the result RAM and
// pulses done_o.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i         start-of-layer pulse, only honoured in IDLE
//   busy_o          high whenever the FSM is not in IDLE
//   done_o          one-cycle pulse when the layer completes
//   act_rd_en_o     activation RAM read enable
//   act_addr_o      activation RAM read address
//   act_data_i      activation RAM data, valid one cycle after act_rd_en_o
//   pos_rts_o       broadcast activation valid
//   pos_sow_o       first activation of the window
//   pos_eow_o       last activation of the window
//   pos_posit_o     broadcast activation
//   pos_rtr_i       per-positron ready (all must be high to transfer)
//   pos_res_rts_i   per-positron result valid
//   pos_res_i       packed results, positron k at [k*POSIT_WIDTH +: POSIT_WIDTH]
//   pos_res_rtr_o   per-positron result ready
//   res_we_o        result RAM write enable
//   res_addr_o      result RAM address
//   res_data_o      result RAM write data
//
// States
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | waiting for start_i
//   ST_STREAM  | reading activations and broadcasting them to the positrons
//   ST_COLLECT | capturing one result per positron
//   ST_WRITE   | writing captured results to the result RAM, one per cycle
//   ST_DONE    | done_o pulse, captured mask cleared
// ---------------------------------------------------------------------------
module positron_layer_sequencer #(
  parameter int POSIT_WIDTH    = 4,
  parameter int NB_UPSTREAM    = 784,
  parameter int NB_POSITRON    = 16,
  parameter int ACT_ADDR_WIDTH = $clog2(NB_UPSTREAM),
  parameter int RES_ADDR_WIDTH = (NB_POSITRON > 1) ? $clog2(NB_POSITRON) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             act_rd_en_o,
  output logic [ACT_ADDR_WIDTH-1:0]        act_addr_o,
  input  logic [POSIT_WIDTH-1:0]           act_data_i,
  output logic                             pos_rts_o,
  output logic                             pos_sow_o,
  output logic                             pos_eow_o,
  output logic [POSIT_WIDTH-1:0]           pos_posit_o,
  input  logic [NB_POSITRON-1:0]           pos_rtr_i,
  input  logic [NB_POSITRON-1:0]           pos_res_rts_i,
  input  logic [NB_POSITRON*POSIT_WIDTH-1:0] pos_res_i,
  output logic [NB_POSITRON-1:0]           pos_res_rtr_o,
  output logic                             res_we_o,
  output logic [RES_ADDR_WIDTH-1:0]        res_addr_o,
  output logic [POSIT_WIDTH-1:0]           res_data_o
);

  // One extra bit so the read pointer can reach NB_UPSTREAM itself.
  localparam int CNT_W = ACT_ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]          UPSTREAM_N = CNT_W'(NB_UPSTREAM);
  localparam logic [CNT_W-1:0]          LAST_ACT   = CNT_W'(NB_UPSTREAM - 1);
  localparam logic [RES_ADDR_WIDTH-1:0] LAST_RES   = RES_ADDR_WIDTH'(NB_POSITRON - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STREAM  = 3'd1,
    ST_COLLECT = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t                    state;
  logic [CNT_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          send_cnt;
  logic [POSIT_WIDTH-1:0]    fifo_mem [2];
  logic                      fifo_wr_sel;
  logic                      fifo_rd_sel;
  logic [1:0]                fifo_cnt;
  logic                      rd_inflight;
  logic [NB_POSITRON-1:0]    captured;
  logic [POSIT_WIDTH-1:0]    res_reg [NB_POSITRON];
  logic [RES_ADDR_WIDTH-1:0] wr_idx;

  logic                      in_stream;
  logic                      in_collect;
  logic                      fifo_nempty;
  logic                      xfer;
  logic [2:0]                credit;
  logic                      rd_issue;
  logic [NB_POSITRON-1:0]    cap;

  always_comb begin
    in_stream   = (state == ST_STREAM);
    in_collect  = (state == ST_COLLECT);
    fifo_nempty = (fifo_cnt != 2'd0);
    xfer        = in_stream && fifo_nempty && (&pos_rtr_i);
    // Slots already claimed by stored entries and the outstanding read. A
    // transfer this cycle frees its slot in time for the next push, which is
    // what lets a 2-entry FIFO sustain one activation per cycle.
    credit      = {1'b0, fifo_cnt} + {2'b00, rd_inflight} - {2'b00, xfer};
    rd_issue    = in_stream && (rd_ptr < UPSTREAM_N) && (credit < 3'd2);
    cap         = pos_res_rts_i & pos_res_rtr_o;
  end

  always_comb begin
    busy_o        = (state != ST_IDLE);
    done_o        = (state == ST_DONE);
    act_rd_en_o   = rd_issue;
    act_addr_o    = rd_issue ? rd_ptr[ACT_ADDR_WIDTH-1:0] : '0;
    pos_rts_o     = in_stream && fifo_nempty;
    pos_sow_o     = pos_rts_o && (send_cnt == '0);
    pos_eow_o     = pos_rts_o && (send_cnt == LAST_ACT);
    pos_posit_o   = fifo_mem[fifo_rd_sel];
    pos_res_rtr_o = in_collect ? ~captured : '0;
    res_we_o      = (state == ST_WRITE);
    res_addr_o    = res_we_o ? wr_idx : '0;
    res_data_o    = res_we_o ? res_reg[wr_idx] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rd_ptr      <= '0;
      send_cnt    <= '0;
      fifo_wr_sel <= 1'b0;
      fifo_rd_sel <= 1'b0;
      fifo_cnt    <= 2'd0;
      rd_inflight <= 1'b0;
      captured    <= '0;
      wr_idx      <= '0;
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      for (int k = 0; k < NB_POSITRON; k++) res_reg[k] <= '0;
    end else begin
      rd_inflight <= rd_issue;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state       <= ST_STREAM;
            rd_ptr      <= '0;
            send_cnt    <= '0;
            fifo_wr_sel <= 1'b0;
            fifo_rd_sel <= 1'b0;
            fifo_cnt    <= 2'd0;
          end
        end
        ST_STREAM: begin
          if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
          // RAM data lands one cycle after its read enable.
          if (rd_inflight) begin
            fifo_mem[fifo_wr_sel] <= act_data_i;
            fifo_wr_sel           <= ~fifo_wr_sel;
          end
          if (xfer) begin
            fifo_rd_sel <= ~fifo_rd_sel;
            send_cnt    <= send_cnt + 1'b1;
            if (send_cnt == LAST_ACT) state <= ST_COLLECT;
          end
          fifo_cnt <= fifo_cnt + {1'b0, rd_inflight} - {1'b0, xfer};
        end
        ST_COLLECT: begin
          for (int k = 0; k < NB_POSITRON; k++) begin
            if (cap[k]) res_reg[k] <= pos_res_i[k*POSIT_WIDTH +: POSIT_WIDTH];
          end
          captured <= captured | cap;
          // Uses the registered mask, so WRITE follows the last capture by a cycle.
          if (&captured) begin
            state  <= ST_WRITE;
            wr_idx <= '0;
          end
        end
        ST_WRITE: begin
          if (wr_idx == LAST_RES) state <= ST_DONE;
          else                    wr_idx <= wr_idx + 1'b1;
        end
        ST_DONE: begin
          captured <= '0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_positron_layer_sequencer.sv
module tb_positron_layer_sequencer;
  localparam int W  = 4;
  localparam int NU = 4;
  localparam int NP = 2;
  localparam int AW = 2;
  localparam int RW = 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start_i = 1'b0;
  logic            busy_o, done_o, act_rd_en_o;
  logic [AW-1:0]   act_addr_o;
  logic [W-1:0]    act_data_i = '0;
  logic            pos_rts_o, pos_sow_o, pos_eow_o;
  logic [W-1:0]    pos_posit_o;
  logic [NP-1:0]   pos_rtr_i = '1;
  logic [NP-1:0]   pos_res_rts_i = '0;
  logic [NP*W-1:0] pos_res_i = '0;
  logic [NP-1:0]   pos_res_rtr_o;
  logic            res_we_o;
  logic [RW-1:0]   res_addr_o;
  logic [W-1:0]    res_data_o;

  positron_layer_sequencer #(
    .POSIT_WIDTH(W), .NB_UPSTREAM(NU), .NB_POSITRON(NP),
    .ACT_ADDR_WIDTH(AW), .RES_ADDR_WIDTH(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .act_rd_en_o(act_rd_en_o), .act_addr_o(act_addr_o), .act_data_i(act_data_i),
    .pos_rts_o(pos_rts_o), .pos_sow_o(pos_sow_o), .pos_eow_o(pos_eow_o),
    .pos_posit_o(pos_posit_o), .pos_rtr_i(pos_rtr_i), .pos_res_rts_i(pos_res_rts_i),
    .pos_res_i(pos_res_i), .pos_res_rtr_o(pos_res_rtr_o), .res_we_o(res_we_o),
    .res_addr_o(res_addr_o), .res_data_o(res_data_o)
  );

  always #5 clk = ~clk;

  // Activation RAM: one-cycle read latency.
  logic [W-1:0] ram [NU];
  always @(posedge clk) if (act_rd_en_o) act_data_i <= ram[act_addr_o];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int start_cyc, first_rts_cyc, done_cyc;
  int rd_seen, xfer_seen, wr_seen, done_seen;
  int exp_act [NU];
  int exp_res [NP];
  bit held;
  int held_val;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int any_out();
    return int'(|{busy_o, done_o, act_rd_en_o, act_addr_o, pos_rts_o, pos_sow_o,
                  pos_eow_o, pos_posit_o, pos_res_rtr_o, res_we_o, res_addr_o, res_data_o});
  endfunction

  // Model: the window is the RAM contents in address order, every positron
  // sees each activation exactly once, and result k is written to address k.
  task automatic sample();
    bit fire;
    if (!rst_n) begin
      held = 0;
      return;
    end
    if (act_rd_en_o) begin
      check("rd_addr", int'(act_addr_o), rd_seen);
      rd_seen++;
    end
    if (held) begin
      check("hold_rts", int'(pos_rts_o), 1);
      check("hold_data", int'(pos_posit_o), held_val);
    end
    if (pos_rts_o && first_rts_cyc < 0) first_rts_cyc = cyc;
    fire = pos_rts_o && (&pos_rtr_i);
    if (fire) begin
      if (xfer_seen < NU) begin
        check("xfer_data", int'(pos_posit_o), exp_act[xfer_seen]);
        check("xfer_sow", int'(pos_sow_o), int'(xfer_seen == 0));
        check("xfer_eow", int'(pos_eow_o), int'(xfer_seen == NU - 1));
      end else begin
        check("extra_xfer", xfer_seen, NU - 1);
      end
      xfer_seen++;
    end
    if (!pos_rts_o) check("idle_framing", int'({pos_sow_o, pos_eow_o}), 0);
    if (act_rd_en_o) check("outstanding_le2", int'(rd_seen - xfer_seen <= 2), 1);
    held     = pos_rts_o && !fire;
    held_val = int'(pos_posit_o);
    if (res_we_o) begin
      if (wr_seen < NP) begin
        check("wr_addr", int'(res_addr_o), wr_seen);
        check("wr_data", int'(res_data_o), exp_res[wr_seen]);
      end else begin
        check("extra_write", wr_seen, NP - 1);
      end
      wr_seen++;
    end
    if (done_o) begin
      done_seen++;
      done_cyc = cyc;
      check("done_after_writes", wr_seen, NP);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_layer(input int r0, input int r1);
    rd_seen = 0; xfer_seen = 0; wr_seen = 0; done_seen = 0;
    first_rts_cyc = -1; done_cyc = -1; held = 0;
    for (int i = 0; i < NU; i++) exp_act[i] = int'(ram[i]);
    exp_res[0] = r0;
    exp_res[1] = r1;
    start_cyc = cyc;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_xfers(input int n);
    int b = 0;
    while (xfer_seen < n && b < 40) begin tick(); b++; end
    check("wait_xfers_timeout", int'(xfer_seen >= n), 1);
  endtask

  task automatic wait_done();
    int b = 0;
    while (done_seen < 1 && b < 40) begin tick(); b++; end
    check("wait_done_timeout", done_seen, 1);
  endtask

  task automatic end_run();
    check("run_reads", rd_seen, NU);
    check("run_xfers", xfer_seen, NU);
    check("run_writes", wr_seen, NP);
    check("run_dones", done_seen, 1);
  endtask

  task automatic collect_same(input int r0, input int r1);
    check("rtr_before_capture", int'(pos_res_rtr_o), 3);
    pos_res_rts_i = 2'b11;
    pos_res_i     = {4'(r1), 4'(r0)};
    tick();
    check("rtr_after_capture", int'(pos_res_rtr_o), 0);
    pos_res_rts_i = 2'b00;
    tick();
    check("write_starts", int'(res_we_o), 1);
    check("write_first_addr", int'(res_addr_o), 0);
  endtask

  initial begin
    for (int i = 0; i < NU; i++) ram[i] = 4'(i + 1);

    // Reset
    tick();
    check("reset_outs", any_out(), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_busy", int'(busy_o), 0);

    // Run A: full throughput, both results in the same cycle
    start_layer(5, 10);
    wait_xfers(NU);
    check("first_rts_latency", first_rts_cyc - start_cyc, 3);
    collect_same(5, 10);
    wait_done();
    check("layer_latency", done_cyc - start_cyc, 11);
    check("busy_falls", int'(busy_o), 0);
    end_run();

    // Run B: stall while one positron is not ready, staggered results,
    // start_i during STREAM and WRITE ignored
    start_layer(3, 7);
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    pos_rtr_i = 2'b01;
    tick();
    check("stall_rts", int'(pos_rts_o), 1);
    check("stall_value", int'(pos_posit_o), 2);
    tick();
    tick();
    pos_rtr_i = 2'b11;
    wait_xfers(NU);
    check("stag_rtr0", int'(pos_res_rtr_o), 3);
    pos_res_rts_i = 2'b10;
    pos_res_i     = {4'h7, 4'h0};
    tick();
    check("stag_rtr1", int'(pos_res_rtr_o), 1);
    pos_res_rts_i = 2'b00;
    tick();
    pos_res_rts_i = 2'b01;
    pos_res_i     = {4'hF, 4'h3};
    tick();
    check("stag_rtr2", int'(pos_res_rtr_o), 0);
    pos_res_rts_i = 2'b00;
    tick();
    check("stag_write", int'(res_we_o), 1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done();
    end_run();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_restart_busy", int'(busy_o), 0);
    end
    check("no_restart_reads", rd_seen, NU);

    // Run D: reset after two transfers, then a clean run with new data
    for (int i = 0; i < NU; i++) ram[i] = 4'(5 + i);
    start_layer(0, 0);
    wait_xfers(2);
    rst_n = 1'b0;
    tick();
    check("midreset_outs", any_out(), 0);
    check("aborted_no_done", done_seen, 0);
    check("aborted_xfers", xfer_seen, 2);
    rst_n = 1'b1;
    for (int i = 0; i < NU; i++) ram[i] = 4'(12 + i);
    tick();
    check("post_reset_idle", int'(busy_o), 0);
    start_layer(1, 2);
    wait_xfers(NU);
    check("restart_rts_latency", first_rts_cyc - start_cyc, 3);
    collect_same(1, 2);
    wait_done();
    end_run();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
